// File: rtl/filter_pkg.sv
// Shared types for the filter/merge block: FSM state encoding and filter mode constants.
package filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PAD   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_PASS  = 1'b0;
    localparam logic MODE_MATCH = 1'b1;

endpackage

// File: rtl/filter_match.sv
// Masked equality compare: a beat hits when every bit selected by mask equals target.
module filter_match #(
    parameter int DATA_WIDTH = 128
) (
    input  logic [DATA_WIDTH-1:0] beat,
    input  logic [DATA_WIDTH-1:0] target,
    input  logic [DATA_WIDTH-1:0] mask,
    output logic                  hit
);

    assign hit = (((beat ^ target) & mask) == '0);

endmodule

// File: rtl/filter_merge.sv
// Drains NUM_CH FWFT input FIFOs in channel order into one output FIFO, optionally
// filtering beats by a masked match, then pads the output to a multiple of PAD_BEATS.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for paritition_done; mode/target/mask latched on start
// ST_DRAIN | popping channel ch until empty, then advancing to the next
// ST_PAD   | writing count as filler until count is PAD_BEATS aligned
// ST_DONE  | publishing len and pulsing process_done for one cycle
module filter_merge
    import filter_pkg::*;
#(
    parameter int TCQ        = 1,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_CH     = 4,
    parameter int PAD_BEATS  = 64
) (
    input  logic                         user_clk,
    input  logic                         user_rst,
    input  logic                         paritition_done,
    output logic                         process_done,
    input  logic                         mode,
    input  logic [DATA_WIDTH-1:0]        target,
    input  logic [DATA_WIDTH-1:0]        mask,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_dout,
    input  logic [NUM_CH-1:0]            data_empty,
    output logic [NUM_CH-1:0]            data_rd_en,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         wr_en,
    input  logic                         full,
    output logic [31:0]                  len
);

    localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0]     PAD_MASK = 32'(PAD_BEATS - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    // Register timing is left to the implementation flow; TCQ is kept for interface compatibility.
    logic unused_tcq;
    assign unused_tcq = (TCQ != 0);

    state_t                  state;
    logic [CH_W-1:0]         ch;
    logic [31:0]             count;
    logic                    mode_q;
    logic [DATA_WIDTH-1:0]   target_q;
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [DATA_WIDTH-1:0]   cur_beat;
    logic                    hit;
    logic                    take_beat;
    logic                    pad_aligned;

    always_comb begin
        cur_beat = data_dout[0 +: DATA_WIDTH];
        for (int i = 1; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) begin
                cur_beat = data_dout[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    filter_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_match (
        .beat   (cur_beat),
        .target (target_q),
        .mask   (mask_q),
        .hit    (hit)
    );

    assign take_beat   = (mode_q == MODE_PASS) || ((mode_q == MODE_MATCH) && hit);
    assign pad_aligned = ((count & PAD_MASK) == 32'd0);

    // Pop is gated by reset so nothing leaves an input FIFO in the reset cycle.
    always_comb begin
        data_rd_en = '0;
        if (user_rst && (state == ST_DRAIN) && !full && !data_empty[ch]) begin
            data_rd_en[ch] = 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst) begin
            state        <= ST_IDLE;
            dout         <= '0;
            wr_en        <= 1'b0;
            len          <= 32'd0;
            process_done <= 1'b0;
            count        <= 32'd0;
            ch           <= '0;
            mode_q       <= MODE_PASS;
            target_q     <= '0;
            mask_q       <= '0;
        end else begin
            wr_en        <= 1'b0;
            process_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (paritition_done) begin
                        state    <= ST_DRAIN;
                        count    <= 32'd0;
                        ch       <= '0;
                        mode_q   <= mode;
                        target_q <= target;
                        mask_q   <= mask;
                    end
                end
                ST_DRAIN: begin
                    if (!full) begin
                        if (data_empty[ch]) begin
                            if (ch == LAST_CH) begin
                                state <= ST_PAD;
                            end else begin
                                ch <= ch + 1'b1;
                            end
                        end else if (take_beat) begin
                            dout  <= cur_beat;
                            wr_en <= 1'b1;
                            count <= count + 32'd1;
                        end
                    end
                end
                ST_PAD: begin
                    if (pad_aligned) begin
                        state <= ST_DONE;
                    end else if (!full) begin
                        dout  <= DATA_WIDTH'(count);
                        wr_en <= 1'b1;
                        count <= count + 32'd1;
                    end
                end
                ST_DONE: begin
                    len          <= count;
                    process_done <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_merge.sv
// Self-checking bench for filter_merge: queue-based FIFO models and a list-level reference model.
module tb_filter_merge;

    localparam int DW   = 128;
    localparam int NCH  = 4;
    localparam int PADB = 64;

    logic              user_clk = 1'b0;
    logic              user_rst;
    logic              paritition_done;
    logic              process_done;
    logic              mode;
    logic [DW-1:0]     target;
    logic [DW-1:0]     mask;
    logic [NCH*DW-1:0] data_dout;
    logic [NCH-1:0]    data_empty;
    logic [NCH-1:0]    data_rd_en;
    logic [DW-1:0]     dout;
    logic              wr_en;
    logic              full;
    logic [31:0]       len;

    always #5 user_clk = ~user_clk;

    filter_merge #(
        .TCQ        (1),
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .PAD_BEATS  (PADB)
    ) dut (
        .user_clk        (user_clk),
        .user_rst        (user_rst),
        .paritition_done (paritition_done),
        .process_done    (process_done),
        .mode            (mode),
        .target          (target),
        .mask            (mask),
        .data_dout       (data_dout),
        .data_empty      (data_empty),
        .data_rd_en      (data_rd_en),
        .dout            (dout),
        .wr_en           (wr_en),
        .full            (full),
        .len             (len)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifo_q [NCH][$];
    logic [DW-1:0] stim_q [NCH][$];
    logic [DW-1:0] got [$];
    logic [DW-1:0] exp_q [$];
    int            pops, done_cnt, pop_while_full, underflow, cyc;
    logic [NCH-1:0] snap;
    logic           snap_full;

    task automatic drive_fifos();
        for (int i = 0; i < NCH; i++) begin
            data_empty[i] = (fifo_q[i].size() == 0);
            if (fifo_q[i].size() == 0) data_dout[i*DW +: DW] = '0;
            else                       data_dout[i*DW +: DW] = fifo_q[i][0];
        end
    endtask

    // One clock: sample pops just before the edge, observe outputs 1 time unit after it.
    task automatic tick();
        #1;
        snap      = data_rd_en;
        snap_full = full;
        @(posedge user_clk);
        #1;
        if (snap_full && (snap != '0)) pop_while_full++;
        for (int i = 0; i < NCH; i++) begin
            if (snap[i]) begin
                if (fifo_q[i].size() == 0) underflow++;
                else begin
                    void'(fifo_q[i].pop_front());
                    pops++;
                end
            end
        end
        if (wr_en) got.push_back(dout);
        if (process_done) done_cnt++;
        drive_fifos();
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NCH; i++) begin
            stim_q[i].delete();
            fifo_q[i].delete();
        end
        drive_fifos();
    endtask

    task automatic load(input int c, input logic [DW-1:0] b);
        fifo_q[c].push_back(b);
        stim_q[c].push_back(b);
        drive_fifos();
    endtask

    function automatic logic [DW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: concatenate channels in order, keep matching beats, pad with running index.
    function automatic void build_expected(input logic m, input logic [DW-1:0] t, input logic [DW-1:0] mk);
        int n;
        logic [DW-1:0] v;
        exp_q.delete();
        for (int c = 0; c < NCH; c++) begin
            foreach (stim_q[c][k]) begin
                if (!m || (((stim_q[c][k] ^ t) & mk) == '0)) exp_q.push_back(stim_q[c][k]);
            end
        end
        n = exp_q.size();
        while ((n % PADB) != 0) begin
            v = '0;
            v[31:0] = n;
            exp_q.push_back(v);
            n++;
        end
    endfunction

    function automatic int first_diff();
        int lim;
        lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < lim; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return lim;
        return -1;
    endfunction

    // Start a run and clock until process_done (bounded); cyc = cycles after the start edge, -1 on timeout.
    task automatic do_run(input int full_pct, input int stall_at, input int stall_len, input int pulse_at);
        int n;
        got.delete();
        pops = 0; done_cnt = 0; pop_while_full = 0; underflow = 0;
        full = 1'b0;
        paritition_done = 1'b1;
        tick();
        paritition_done = 1'b0;
        mode   = 1'($urandom);
        target = rand_beat();
        mask   = rand_beat();
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            if (stall_at >= 0) full = (n >= stall_at) && (n < stall_at + stall_len);
            else               full = ($urandom_range(99) < full_pct);
            paritition_done = (n == pulse_at);
            tick();
            n++;
        end
        cyc = (done_cnt == 0) ? -1 : n;
        full = 1'b0;
        paritition_done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        user_rst = 1'b0;
        paritition_done = 1'b1;
        pops = 0; done_cnt = 0; got.delete();
        load(0, 128'h55);
        repeat (3) tick();
        total++; if (data_rd_en !== '0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", data_rd_en); end
        total++; if (wr_en !== 1'b0 || process_done !== 1'b0) begin bad++; $display("FAIL reset_flags: wr_en=%b done=%b want 0", wr_en, process_done); end
        total++; if (len !== 32'd0 || dout !== '0) begin bad++; $display("FAIL reset_regs: len=%0d dout=%h want 0", len, dout); end
        total++; if (pops != 0) begin bad++; $display("FAIL reset_pops: got %0d want 0", pops); end
        paritition_done = 1'b0;
        user_rst = 1'b1;
        repeat (3) tick();
        total++; if (pops != 0 || got.size() != 0) begin bad++; $display("FAIL reset_release: pops=%0d writes=%0d want 0", pops, got.size()); end
        clear_stim();
    endtask

    task automatic test_pass_ch3();
        int d;
        clear_stim();
        for (int k = 0; k < 5; k++) load(3, rand_beat());
        mode = 1'b0; target = '0; mask = '0;
        build_expected(1'b0, '0, '0);
        do_run(0, -1, 0, -1);
        d = first_diff();
        total++; if (d >= 0) begin bad++; $display("FAIL pass_ch3_seq: idx %0d got %0d beats want %0d", d, got.size(), exp_q.size()); end
        total++; if (len !== 32'd64) begin bad++; $display("FAIL pass_ch3_len: got %0d want 64", len); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL pass_ch3_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_match();
        int d;
        logic [DW-1:0] t, m;
        clear_stim();
        load(0, 128'h12); load(0, 128'h13); load(0, 128'h112);
        t = 128'h12; m = 128'hFF;
        mode = 1'b1; target = t; mask = m;
        build_expected(1'b1, t, m);
        do_run(0, -1, 0, -1);
        d = first_diff();
        total++; if (pops != 3) begin bad++; $display("FAIL match_pops: got %0d want 3", pops); end
        total++; if (d >= 0) begin bad++; $display("FAIL match_seq: idx %0d got %0d beats want %0d", d, got.size(), exp_q.size()); end
        total++; if (len !== 32'd64) begin bad++; $display("FAIL match_len: got %0d want 64", len); end
    endtask

    task automatic test_all_empty();
        clear_stim();
        mode = 1'b0;
        do_run(0, -1, 0, -1);
        total++; if (cyc != 6) begin bad++; $display("FAIL empty_latency: got %0d cycles want 6", cyc); end
        total++; if (got.size() != 0) begin bad++; $display("FAIL empty_writes: got %0d want 0", got.size()); end
        total++; if (len !== 32'd0) begin bad++; $display("FAIL empty_len: got %0d want 0", len); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL empty_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_stall();
        int d;
        clear_stim();
        for (int k = 0; k < 64; k++) load(1, rand_beat());
        mode = 1'b0;
        build_expected(1'b0, '0, '0);
        do_run(0, 30, 10, -1);
        d = first_diff();
        total++; if (pop_while_full != 0) begin bad++; $display("FAIL stall_pop: got %0d pops while full want 0", pop_while_full); end
        total++; if (d >= 0) begin bad++; $display("FAIL stall_seq: idx %0d got %0d beats want %0d", d, got.size(), exp_q.size()); end
        total++; if (len !== 32'd64) begin bad++; $display("FAIL stall_len: got %0d want 64", len); end
    endtask

    task automatic test_reset_mid_pad();
        int n, d;
        clear_stim();
        for (int k = 0; k < 3; k++) load(0, rand_beat());
        mode = 1'b0;
        got.delete();
        paritition_done = 1'b1;
        tick();
        paritition_done = 1'b0;
        n = 0;
        while (got.size() < 6 && n < 200) begin tick(); n++; end
        total++; if (n >= 200) begin bad++; $display("FAIL midpad_reach: got %0d writes want 6 within 200 cycles", got.size()); end
        user_rst = 1'b0;
        tick();
        total++; if (wr_en !== 1'b0 || process_done !== 1'b0) begin bad++; $display("FAIL midpad_reset: wr_en=%b done=%b want 0", wr_en, process_done); end
        total++; if (len !== 32'd0) begin bad++; $display("FAIL midpad_len_clr: got %0d want 0", len); end
        user_rst = 1'b1;
        got.delete(); done_cnt = 0;
        repeat (5) tick();
        total++; if (got.size() != 0 || done_cnt != 0) begin bad++; $display("FAIL midpad_idle: writes=%0d done=%0d want 0", got.size(), done_cnt); end
        clear_stim();
        for (int k = 0; k < 7; k++) load(2, rand_beat());
        build_expected(1'b0, '0, '0);
        mode = 1'b0;
        do_run(0, -1, 0, -1);
        d = first_diff();
        total++; if (d >= 0 || len !== 32'd64) begin bad++; $display("FAIL midpad_rerun: idx %0d len %0d want 64", d, len); end
    endtask

    task automatic test_restart_ignored();
        int d;
        clear_stim();
        for (int k = 0; k < 10; k++) load(0, rand_beat());
        for (int k = 0; k < 5; k++) load(2, rand_beat());
        mode = 1'b0;
        build_expected(1'b0, '0, '0);
        do_run(0, -1, 0, 4);
        d = first_diff();
        total++; if (done_cnt != 1) begin bad++; $display("FAIL restart_done: got %0d pulses want 1", done_cnt); end
        total++; if (d >= 0) begin bad++; $display("FAIL restart_seq: idx %0d got %0d beats want %0d", d, got.size(), exp_q.size()); end
        total++; if (len !== 32'(exp_q.size())) begin bad++; $display("FAIL restart_len: got %0d want %0d", len, exp_q.size()); end
    endtask

    task automatic test_random();
        int d, nb;
        logic m;
        logic [DW-1:0] t, mk, b;
        for (int r = 0; r < 6; r++) begin
            clear_stim();
            m  = 1'($urandom);
            t  = rand_beat();
            mk = '0;
            mk[3:0] = 4'($urandom);
            for (int c = 0; c < NCH; c++) begin
                nb = $urandom_range(30);
                for (int k = 0; k < nb; k++) begin
                    b = t;
                    b[3:0] = 4'($urandom);
                    if ($urandom_range(3) == 0) b = rand_beat();
                    load(c, b);
                end
            end
            mode = m; target = t; mask = mk;
            build_expected(m, t, mk);
            do_run(30, -1, 0, -1);
            d = first_diff();
            total++; if (d >= 0) begin bad++; $display("FAIL rand%0d_seq: idx %0d got %0d beats want %0d", r, d, got.size(), exp_q.size()); end
            total++; if (len !== 32'(exp_q.size())) begin bad++; $display("FAIL rand%0d_len: got %0d want %0d", r, len, exp_q.size()); end
            total++; if (done_cnt != 1 || pop_while_full != 0 || underflow != 0) begin
                bad++; $display("FAIL rand%0d_ctrl: done=%0d pop_full=%0d underflow=%0d want 1/0/0", r, done_cnt, pop_while_full, underflow);
            end
        end
    endtask

    initial begin
        user_rst = 1'b0;
        paritition_done = 1'b0;
        mode = 1'b0;
        target = '0;
        mask = '0;
        full = 1'b0;
        data_dout = '0;
        data_empty = '1;
        test_reset();
        test_pass_ch3();
        test_match();
        test_all_empty();
        test_stall();
        test_reset_mid_pad();
        test_restart_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
